// File: rtl/locking_rr_arbiter_pkg.sv
// Shared constants and helpers for the locking round-robin stream arbiter.
package locking_rr_arbiter_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef enum logic {
        LK_OPEN = 1'b0,
        LK_HELD = 1'b1
    } lock_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) r++;
        return r;
    endfunction

    // Index width: at least one bit even for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/locking_rr_arbiter_rr_priority_select.sv
// Combinational rotate / lowest-set-bit / rotate-back request selector.
module rr_priority_select
    import locking_rr_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] base,
    input  logic          mode,
    output logic [CW-1:0] idx,
    output logic          any
);

    int unsigned  start;
    int unsigned  pos;
    logic [N-1:0] rot;

    always_comb begin
        start = 0;
        pos   = 0;
        any   = 1'b0;
        if (mode) start = (32'(base) + 1) % N;
        // rot[j] = req[(start + j) mod N]
        rot = N'({req, req} >> start);
        for (int unsigned j = 0; j < N; j++) begin
            if (!any && rot[j]) begin
                any = 1'b1;
                pos = j;
            end
        end
        idx = CW'(N - 1);
        if (any) idx = CW'((start + pos) % N);
    end

endmodule

// File: rtl/locking_rr_arbiter.sv
// N-way ready/valid arbiter with fixed or round-robin priority and
// optional BEATS-beat grant locking; payload path is combinational.
module locking_rr_arbiter
    import locking_rr_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned BEATS = 4,
    parameter int unsigned RR    = 1,
    localparam int unsigned CW   = idx_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    io_in_valid,
    output logic [N-1:0]    io_in_ready,
    input  logic [N*W-1:0]  io_in_bits,
    input  logic [N-1:0]    io_in_lock,
    input  logic            io_out_ready,
    output logic            io_out_valid,
    output logic [W-1:0]    io_out_bits,
    output logic [CW-1:0]   io_chosen,
    output logic            io_locked,
    output logic            io_fire
);

    localparam int unsigned CNT_W   = clog2(BEATS) + 1;
    localparam bit          LOCK_EN = (BEATS > 1);
    localparam bit          MODE_RR = (RR == ARB_RR);

    lock_state_e      state_q, state_n;
    logic [CW-1:0]    ptr_q, ptr_n;
    logic [CW-1:0]    owner_q, owner_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic [CW-1:0]    sel_idx;
    logic             sel_any;
    logic [N-1:0]     onehot;

    rr_priority_select #(.N(N), .CW(CW)) u_select (
        .req  (io_in_valid),
        .base (ptr_q),
        .mode (MODE_RR),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    // State registers: pointer, lock owner and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LK_OPEN;
            ptr_q   <= CW'(N - 1);
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            owner_q <= owner_n;
            cnt_q   <= cnt_n;
        end
    end

    // Grant mux, handshake outputs and next-state.
    always_comb begin
        state_n      = state_q;
        ptr_n        = ptr_q;
        owner_n      = owner_q;
        cnt_n        = cnt_q;

        io_locked    = (state_q == LK_HELD);
        io_chosen    = io_locked ? owner_q : sel_idx;
        onehot       = N'(1) << io_chosen;
        io_out_valid = |(io_in_valid & onehot);
        io_out_bits  = W'(io_in_bits >> (32'(io_chosen) * W));
        io_in_ready  = io_out_ready ? onehot : '0;
        io_fire      = io_out_valid && io_out_ready;

        if (io_fire) begin
            if (MODE_RR) ptr_n = io_chosen;
            case (state_q)
                LK_OPEN: begin
                    if (LOCK_EN && (|(io_in_lock & onehot))) begin
                        state_n = LK_HELD;
                        owner_n = io_chosen;
                        cnt_n   = CNT_W'(1);
                    end
                end
                LK_HELD: begin
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_n = LK_OPEN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                default: state_n = LK_OPEN;
            endcase
        end
    end

    logic unused_any;
    assign unused_any = sel_any;

endmodule
